led_src_arbiter: RTL and testbench

Round-robin arbiter that shares the 8-bit LED bank between N_REQ requesters, one per PLL-clocked pattern source. It gates arbitration on the PLL lock status and holds each grant for a bounded dwell time. It sits between the per-PLL blink logic and the led pins and runs in the clk0_1 domain.

---
 rtl/led_arb_pkg.sv | 34 +++
 rtl/sync_2ff.sv | 26 ++
 rtl/led_src_arbiter.sv | 162 ++++++++++++++++
 tb/tb_led_src_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_arb_pkg.sv
// Shared types, defaults and round-robin search for the LED source arbiter.
package led_arb_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      IDLE      = 2'd1,
      GRANT     = 2'd2
   } arb_state_e;

   localparam int unsigned LED_W_DEF       = 8;
   localparam int unsigned DWELL_DEF       = 16;
   localparam int unsigned LOCK_STABLE_DEF = 8;
   localparam int unsigned N_REQ_MAX       = 8;

   // First set bit of elig searching from last+1, wrapping modulo n (n <= N_REQ_MAX).
   function automatic logic [2:0] rr_next(input logic [7:0]  elig,
                                          input logic [2:0]  last,
                                          input int unsigned n);
      logic [2:0]  idx;
      logic        found;
      int unsigned cand;
      idx   = 3'd0;
      found = 1'b0;
      for (int unsigned i = 1; i <= N_REQ_MAX; i++) begin
         cand = (32'(last) + i) % n;
         if (!found && (i <= n) && elig[3'(cand)]) begin
            idx   = 3'(cand);
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for quasi-static level signals, synchronous active-low clear.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk0_1,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge clk0_1) begin
      if (!rst) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/led_src_arbiter.sv
// Lock-qualified round-robin arbiter sharing the LED bank between PLL pattern sources.
// Build option: LED_ARB_PRIO_EN gives requester 0 preemptive priority.
module led_src_arbiter
   import led_arb_pkg::*;
#(
   parameter int unsigned      N_REQ        = 4,
   parameter int unsigned      LED_W        = LED_W_DEF,
   parameter int unsigned      DWELL        = DWELL_DEF,
   parameter int unsigned      LOCK_STABLE  = LOCK_STABLE_DEF,
   parameter logic [LED_W-1:0] IDLE_PATTERN = '0
) (
   input  logic                       clk0_1,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           lock_in,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*LED_W-1:0]     pattern,
   output logic [N_REQ-1:0]           gnt,
   output logic [LED_W-1:0]           led,
   output logic [$clog2(N_REQ)-1:0]   src_idx,
   output logic                       ready,
   output logic                       lock_lost
);

   localparam int unsigned IDX_W = $clog2(N_REQ);
   localparam int unsigned STB_W = $clog2(LOCK_STABLE + 1);
   localparam int unsigned DWL_W = $clog2(DWELL + 1);

   arb_state_e       r_state, w_state_nxt;
   logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
   logic [LED_W-1:0] r_led, w_led_nxt;
   logic [IDX_W-1:0] r_src_idx, w_src_nxt;
   logic [IDX_W-1:0] r_last_gnt, w_last_nxt;
   logic [STB_W-1:0] r_stable_cnt, w_stable_nxt;
   logic [DWL_W-1:0] r_dwell_cnt, w_dwell_nxt;
   logic             r_ready, r_lock_lost, w_lost_nxt;

   logic [N_REQ-1:0] w_lock_s;
   logic             w_all_lock;
   logic [N_REQ-1:0] w_elig;
   logic [IDX_W-1:0] w_rr, w_winner;
   logic [LED_W-1:0] w_pat_g, w_pat_win;
   logic             w_release, w_preempt;

   sync_2ff #(.WIDTH(N_REQ)) u_lock_sync (
      .clk0_1 (clk0_1),
      .rst    (rst),
      .i_d    (lock_in),
      .o_q    (w_lock_s)
   );

   assign w_all_lock = &w_lock_s;
   assign w_elig     = req & w_lock_s;
   assign w_rr       = IDX_W'(rr_next(8'(w_elig), 3'(r_last_gnt), N_REQ));
   assign w_pat_g    = pattern[32'(r_src_idx) * LED_W +: LED_W];
   assign w_pat_win  = pattern[32'(w_winner) * LED_W +: LED_W];

`ifdef LED_ARB_PRIO_EN
   assign w_winner  = w_elig[0] ? IDX_W'(0) : w_rr;
   assign w_preempt = (r_src_idx != IDX_W'(0)) && w_elig[0];
`else
   assign w_winner  = w_rr;
   assign w_preempt = 1'b0;
`endif

   assign w_release = (r_dwell_cnt == DWL_W'(DWELL - 1)) || !req[r_src_idx] ||
                      !w_lock_s[r_src_idx] || w_preempt;

   // Next-state and next-output logic; lock loss overrides grant and release.
   always_comb begin
      w_state_nxt  = r_state;
      w_gnt_nxt    = r_gnt;
      w_led_nxt    = r_led;
      w_src_nxt    = r_src_idx;
      w_last_nxt   = r_last_gnt;
      w_stable_nxt = r_stable_cnt;
      w_dwell_nxt  = r_dwell_cnt;
      w_lost_nxt   = r_lock_lost;
      if ((r_state != WAIT_LOCK) && !w_all_lock) begin
         w_state_nxt  = WAIT_LOCK;
         w_gnt_nxt    = '0;
         w_led_nxt    = IDLE_PATTERN;
         w_lost_nxt   = 1'b1;
         w_stable_nxt = '0;
      end else begin
         case (r_state)
            WAIT_LOCK: begin
               w_gnt_nxt = '0;
               w_led_nxt = IDLE_PATTERN;
               if (!w_all_lock) begin
                  w_stable_nxt = '0;
               end else if (r_stable_cnt == STB_W'(LOCK_STABLE - 1)) begin
                  w_stable_nxt = '0;
                  w_state_nxt  = IDLE;
               end else begin
                  w_stable_nxt = r_stable_cnt + STB_W'(1);
               end
            end
            IDLE: begin
               if (|w_elig) begin
                  w_gnt_nxt   = N_REQ'(1) << w_winner;
                  w_src_nxt   = w_winner;
                  w_led_nxt   = w_pat_win;
                  w_dwell_nxt = '0;
                  w_state_nxt = GRANT;
               end else begin
                  w_led_nxt = IDLE_PATTERN;
               end
            end
            GRANT: begin
               w_led_nxt   = w_pat_g;
               w_dwell_nxt = r_dwell_cnt + DWL_W'(1);
               if (w_release) begin
                  w_gnt_nxt   = '0;
                  w_led_nxt   = IDLE_PATTERN;
                  w_state_nxt = IDLE;
`ifdef LED_ARB_PRIO_EN
                  if (r_src_idx != IDX_W'(0)) w_last_nxt = r_src_idx;
`else
                  w_last_nxt = r_src_idx;
`endif
               end
            end
            default: begin
               w_state_nxt = WAIT_LOCK;
               w_gnt_nxt   = '0;
               w_led_nxt   = IDLE_PATTERN;
            end
         endcase
      end
   end

   always_ff @(posedge clk0_1) begin
      if (!rst) begin
         r_state      <= WAIT_LOCK;
         r_gnt        <= '0;
         r_led        <= IDLE_PATTERN;
         r_src_idx    <= '0;
         r_last_gnt   <= IDX_W'(N_REQ - 1);
         r_stable_cnt <= '0;
         r_dwell_cnt  <= '0;
         r_ready      <= 1'b0;
         r_lock_lost  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_gnt        <= w_gnt_nxt;
         r_led        <= w_led_nxt;
         r_src_idx    <= w_src_nxt;
         r_last_gnt   <= w_last_nxt;
         r_stable_cnt <= w_stable_nxt;
         r_dwell_cnt  <= w_dwell_nxt;
         r_ready      <= (w_state_nxt != WAIT_LOCK);
         r_lock_lost  <= w_lost_nxt;
      end
   end

   assign gnt       = r_gnt;
   assign led       = r_led;
   assign src_idx   = r_src_idx;
   assign ready     = r_ready;
   assign lock_lost = r_lock_lost;

endmodule

// File: tb/tb_led_src_arbiter.sv
// Scoreboard bench for led_src_arbiter: stimulus queues expected grants, a monitor checks them.
module tb_led_src_arbiter;

   logic        clk0_1;
   logic        rst;
   logic [3:0]  lock_in;
   logic [3:0]  req;
   logic [31:0] pattern;
   logic [3:0]  gnt;
   logic [7:0]  led;
   logic [1:0]  src_idx;
   logic        ready;
   logic        lock_lost;

   typedef struct {
      logic [3:0] g;
      logic [7:0] led;
      logic [1:0] idx;
      int         len;
   } rec_t;

   rec_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   led_src_arbiter #(
      .N_REQ(4), .LED_W(8), .DWELL(4), .LOCK_STABLE(8), .IDLE_PATTERN(8'h00)
   ) dut (
      .clk0_1    (clk0_1),
      .rst       (rst),
      .lock_in   (lock_in),
      .req       (req),
      .pattern   (pattern),
      .gnt       (gnt),
      .led       (led),
      .src_idx   (src_idx),
      .ready     (ready),
      .lock_lost (lock_lost)
   );

   initial clk0_1 = 1'b0;
   always #5 clk0_1 = ~clk0_1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input int idx, input int len);
      rec_t r;
      r.g   = 4'(1 << idx);
      r.led = 8'(8'h11 * (idx + 1));
      r.idx = 2'(idx);
      r.len = len;
      q.push_back(r);
   endtask

   task automatic wait_gnt(input logic [3:0] want);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk0_1);
         if ((want == 4'h0 && gnt != 4'h0) || (want != 4'h0 && gnt == want)) return;
      end
      check("grant_timeout", 32'(gnt), 32'(want));
   endtask

   // Called on the negedge where lock_in was (re)asserted to 4'hF.
   task automatic wait_ready_check();
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk0_1);
         check("ready_early", 32'(ready), 32'd0);
      end
      @(negedge clk0_1);
      check("ready_after_10", 32'(ready), 32'd1);
   endtask

   task automatic do_grant(input logic [3:0] req_v, input int n);
      req = req_v;
      wait_gnt(4'h0);
      for (int i = 1; i < n; i++) @(negedge clk0_1);
      req = 4'h0;
   endtask

   // Monitor: pops an expected record at every grant start, checks contents and length.
   logic [3:0] prev_gnt = 4'h0;
   rec_t       cur;
   int         cur_len = 0;
   always @(negedge clk0_1) begin
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      if (gnt == 4'h0) begin
         check("led_idle", 32'(led), 32'h00);
         if (prev_gnt != 4'h0) check("grant_len", 32'(cur_len), 32'(cur.len));
      end else if (prev_gnt == 4'h0) begin
         if (q.size() == 0) begin
            check("unexpected_grant", 32'(gnt), 32'h0);
            cur.g = gnt; cur.led = led; cur.idx = src_idx; cur.len = 0;
         end else begin
            cur = q.pop_front();
            check("grant_gnt", 32'(gnt), 32'(cur.g));
            check("grant_src_idx", 32'(src_idx), 32'(cur.idx));
         end
         cur_len = 1;
         check("grant_led", 32'(led), 32'(cur.led));
      end else if (gnt != prev_gnt) begin
         check("grant_gap", 32'(gnt), 32'h0);
      end else begin
         cur_len++;
         check("grant_led", 32'(led), 32'(cur.led));
      end
      prev_gnt = gnt;
   end

   initial begin
      rst     = 1'b0;
      lock_in = 4'h0;
      req     = 4'h0;
      pattern = {8'h44, 8'h33, 8'h22, 8'h11};
      repeat (3) @(negedge clk0_1);
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_led", 32'(led), 32'h00);
      check("rst_src_idx", 32'(src_idx), 32'h0);
      check("rst_ready", 32'(ready), 32'h0);
      check("rst_lock_lost", 32'(lock_lost), 32'h0);

      // 1: lock qualification
      rst     = 1'b1;
      lock_in = 4'hF;
      wait_ready_check();

      // 2: round-robin with full dwell
      for (int k = 0; k < 5; k++) push(k % 4, 4);
      req = 4'hF;
      begin
         int seen = 0;
         logic [3:0] pg = 4'h0;
         for (int i = 0; i < 60 && seen < 5; i++) begin
            @(negedge clk0_1);
            if (gnt != 4'h0 && pg == 4'h0) seen++;
            pg = gnt;
         end
         check("rr_grants_seen", 32'(seen), 32'd5);
      end
      repeat (3) @(negedge clk0_1);
      req = 4'h0;
      repeat (2) @(negedge clk0_1);

      // 3: early release and re-grant after a single gap cycle
      push(2, 2);
      do_grant(4'b0100, 2);
      @(negedge clk0_1);
      check("early_rel_gnt", 32'(gnt), 32'h0);
      push(2, 2);
      req = 4'b0100;
      @(negedge clk0_1);
      check("regrant_gnt", 32'(gnt), 32'h4);
      @(negedge clk0_1);
      req = 4'h0;
      repeat (2) @(negedge clk0_1);

      // 4: lock loss during a grant to requester 1
      push(1, 3);
      req = 4'b0010;
      wait_gnt(4'h0);
      lock_in = 4'b1101;
      repeat (2) begin
         @(negedge clk0_1);
         check("ready_before_loss", 32'(ready), 32'd1);
      end
      @(negedge clk0_1);
      check("loss_gnt", 32'(gnt), 32'h0);
      check("loss_ready", 32'(ready), 32'h0);
      check("loss_lock_lost", 32'(lock_lost), 32'h1);
      req     = 4'h0;
      lock_in = 4'hF;
      wait_ready_check();
      check("lock_lost_sticky", 32'(lock_lost), 32'h1);
      repeat (2) @(negedge clk0_1);

      // 5: reset in the middle of a grant
      push(3, 1);
      req = 4'b1000;
      wait_gnt(4'h0);
      rst = 1'b0;
      @(negedge clk0_1);
      check("mid_rst_gnt", 32'(gnt), 32'h0);
      check("mid_rst_led", 32'(led), 32'h00);
      check("mid_rst_src_idx", 32'(src_idx), 32'h0);
      check("mid_rst_ready", 32'(ready), 32'h0);
      check("mid_rst_lock_lost", 32'(lock_lost), 32'h0);
      rst = 1'b1;
      req = 4'hF;
      push(0, 4);
      wait_ready_check();
      wait_gnt(4'h0);
      repeat (3) @(negedge clk0_1);
      req = 4'h0;
      repeat (2) @(negedge clk0_1);

      // 6: requester 0 arriving during a grant to requester 3
`ifdef LED_ARB_PRIO_EN
      push(3, 1);
`else
      push(3, 4);
`endif
      push(0, 4);
      req = 4'b1000;
      wait_gnt(4'h0);
      req = 4'b1001;
      wait_gnt(4'b0001);
      repeat (3) @(negedge clk0_1);
      req = 4'h0;
      repeat (4) @(negedge clk0_1);
      check("scoreboard_drained", 32'(q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
